// File: rtl/imem_responder_if.sv
// Fetch, loader-write and RAM signal bundle for the instruction memory responder.
// slave is the responder's view; master is the fetch unit / loader / RAM side.
interface imem_responder_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              fetch_flush;
  logic              inst_valid;
  logic [DATA_W-1:0] inst;
  logic              inst_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  fetch_req, fetch_addr, fetch_flush, inst_ready,
    input  wr_en, wr_addr, wr_data, ram_rdata,
    output fetch_ready, inst_valid, inst, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output fetch_req, fetch_addr, fetch_flush, inst_ready,
    output wr_en, wr_addr, wr_data, ram_rdata,
    input  fetch_ready, inst_valid, inst, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction fetch responder in front of a single-port synchronous RAM.
// Loader writes take the RAM port first; writes to the pending/held address update inst.
module imem_responder #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst_async_n,
  imem_responder_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              fetch_ready;
  logic              accept;
  logic              wr_hit;

  assign fetch_ready = ((state_q == IDLE) || ((state_q == RESP) && bus.inst_ready))
                       && !bus.wr_en && !bus.fetch_flush;
  assign accept      = bus.fetch_req && fetch_ready;
  assign wr_hit      = bus.wr_en && (bus.wr_addr == addr_q);

  // Write enable is gated by reset so the RAM cannot be disturbed while held in reset.
  assign bus.ram_we      = bus.wr_en && rst_async_n;
  assign bus.ram_addr    = bus.wr_en ? bus.wr_addr : bus.fetch_addr;
  assign bus.ram_wdata   = bus.wr_data;
  assign bus.fetch_ready = fetch_ready;
  assign bus.inst_valid  = (state_q == RESP);
  assign bus.inst        = inst_q;

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = READ;
          addr_d  = bus.fetch_addr;
        end
      end
      READ: begin
        inst_d  = wr_hit ? bus.wr_data : bus.ram_rdata;
        state_d = RESP;
      end
      RESP: begin
        if (wr_hit) begin
          inst_d = bus.wr_data;
        end
        if (bus.inst_ready) begin
          if (accept) begin
            state_d = READ;
            addr_d  = bus.fetch_addr;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.fetch_flush) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      state_q <= IDLE;
      inst_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder with a behavioural synchronous RAM model.
module tb_imem_responder;

  logic clk;
  logic rst_async_n;
  int   total;
  int   bad;

  imem_responder_if #(.ADDR_W(13), .DATA_W(16)) bus ();

  imem_responder #(.ADDR_W(13), .DATA_W(16)) dut (
    .clk         (clk),
    .rst_async_n (rst_async_n),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first single-port RAM: one-cycle read latency.
  logic [15:0] mem [0:8191];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fetch_req   = 1'b0;
    bus.fetch_addr  = '0;
    bus.fetch_flush = 1'b0;
    bus.inst_ready  = 1'b1;
    bus.wr_en       = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
  endtask

  task automatic write_word(input logic [12:0] a, input logic [15:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_async_n = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 13'h0005;
    bus.wr_data = 16'hDEAD;
    repeat (2) tick();
    total++;
    if (bus.inst_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%b want=0", bus.inst_valid);
    end
    total++;
    if (bus.inst !== 16'h0000) begin
      bad++; $display("FAIL reset_inst got=%h want=0000", bus.inst);
    end
    total++;
    if (bus.ram_we !== 1'b0) begin
      bad++; $display("FAIL reset_ram_we got=%b want=0", bus.ram_we);
    end
    $display("reset: valid=%b inst=%h ram_we=%b", bus.inst_valid, bus.inst, bus.ram_we);
    bus.wr_en   = 1'b0;
    rst_async_n = 1'b1;
    tick();
  endtask

  task automatic preload();
    write_word(13'h0010, 16'hA55A);
    write_word(13'h0020, 16'h2222);
    write_word(13'h0030, 16'hBEEF);
    write_word(13'h0031, 16'h0F0F);
    write_word(13'h0040, 16'hC001);
    write_word(13'h0041, 16'hC002);
    write_word(13'h0042, 16'hC003);
    write_word(13'h0043, 16'hC004);
    tick();
  endtask

  task automatic test_basic();
    bus.inst_ready = 1'b1;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 13'h0010;
    #1;
    total++;
    if (bus.fetch_ready !== 1'b1) begin
      bad++; $display("FAIL basic_ready got=%b want=1", bus.fetch_ready);
    end
    tick();
    bus.fetch_req = 1'b0;
    total++;
    if (bus.inst_valid !== 1'b0) begin
      bad++; $display("FAIL basic_read_valid got=%b want=0", bus.inst_valid);
    end
    tick();
    total++;
    if (bus.inst_valid !== 1'b1 || bus.inst !== 16'hA55A) begin
      bad++; $display("FAIL basic_resp got=%b/%h want=1/a55a", bus.inst_valid, bus.inst);
    end
    $display("basic: addr=0010 valid=%b inst=%h", bus.inst_valid, bus.inst);
    tick();
    total++;
    if (bus.inst_valid !== 1'b0) begin
      bad++; $display("FAIL basic_one_cycle got=%b want=0", bus.inst_valid);
    end
  endtask

  task automatic test_hold();
    bus.inst_ready = 1'b0;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 13'h0020;
    tick();
    bus.fetch_addr = 13'h0010;
    tick();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.inst_valid !== 1'b1 || bus.inst !== 16'h2222 || bus.fetch_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_%0d got=%b/%h/rdy%b want=1/2222/rdy0",
                 i, bus.inst_valid, bus.inst, bus.fetch_ready);
      end
      $display("hold: cycle=%0d valid=%b inst=%h ready=%b", i, bus.inst_valid, bus.inst, bus.fetch_ready);
      tick();
    end
    bus.fetch_req  = 1'b0;
    bus.inst_ready = 1'b1;
    tick();
    total++;
    if (bus.inst_valid !== 1'b0) begin
      bad++; $display("FAIL hold_release got=%b want=0", bus.inst_valid);
    end
  endtask

  task automatic test_write_priority();
    bus.inst_ready = 1'b1;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 13'h0020;
    bus.wr_en      = 1'b1;
    bus.wr_addr    = 13'h0050;
    bus.wr_data    = 16'h5555;
    #1;
    total++;
    if (bus.fetch_ready !== 1'b0 || bus.ram_we !== 1'b1 || bus.ram_addr !== 13'h0050) begin
      bad++;
      $display("FAIL wprio_block got=rdy%b/we%b/%h want=rdy0/we1/0050",
               bus.fetch_ready, bus.ram_we, bus.ram_addr);
    end
    tick();
    bus.wr_en = 1'b0;
    #1;
    total++;
    if (bus.inst_valid !== 1'b0 || bus.fetch_ready !== 1'b1 || bus.ram_addr !== 13'h0020
        || bus.ram_we !== 1'b0) begin
      bad++;
      $display("FAIL wprio_retry got=v%b/rdy%b/%h/we%b want=v0/rdy1/0020/we0",
               bus.inst_valid, bus.fetch_ready, bus.ram_addr, bus.ram_we);
    end
    tick();
    bus.fetch_req = 1'b0;
    tick();
    total++;
    if (bus.inst_valid !== 1'b1 || bus.inst !== 16'h2222) begin
      bad++; $display("FAIL wprio_resp got=%b/%h want=1/2222", bus.inst_valid, bus.inst);
    end
    $display("wprio: addr=0020 valid=%b inst=%h", bus.inst_valid, bus.inst);
    tick();
  endtask

  task automatic test_bypass();
    bus.inst_ready = 1'b1;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 13'h0030;
    tick();
    bus.fetch_req = 1'b0;
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 13'h0030;
    bus.wr_data   = 16'h1234;
    tick();
    bus.wr_en = 1'b0;
    total++;
    if (bus.inst_valid !== 1'b1 || bus.inst !== 16'h1234) begin
      bad++; $display("FAIL bypass_hit got=%b/%h want=1/1234", bus.inst_valid, bus.inst);
    end
    $display("bypass: hit inst=%h", bus.inst);
    tick();
    bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 13'h0031;
    bus.wr_data   = 16'h7777;
    tick();
    bus.wr_en = 1'b0;
    total++;
    if (bus.inst_valid !== 1'b1 || bus.inst !== 16'h1234) begin
      bad++; $display("FAIL bypass_miss got=%b/%h want=1/1234", bus.inst_valid, bus.inst);
    end
    $display("bypass: miss inst=%h", bus.inst);
    tick();
  endtask

  task automatic test_coherency();
    bus.inst_ready = 1'b0;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 13'h0020;
    tick();
    bus.fetch_req = 1'b0;
    tick();
    bus.wr_en   = 1'b1;
    bus.wr_addr = 13'h0020;
    bus.wr_data = 16'h3333;
    tick();
    total++;
    if (bus.inst_valid !== 1'b1 || bus.inst !== 16'h3333) begin
      bad++; $display("FAIL coh_hit got=%b/%h want=1/3333", bus.inst_valid, bus.inst);
    end
    bus.wr_addr = 13'h0021;
    bus.wr_data = 16'h4444;
    tick();
    bus.wr_en = 1'b0;
    total++;
    if (bus.inst_valid !== 1'b1 || bus.inst !== 16'h3333) begin
      bad++; $display("FAIL coh_miss got=%b/%h want=1/3333", bus.inst_valid, bus.inst);
    end
    $display("coherency: valid=%b inst=%h", bus.inst_valid, bus.inst);
    bus.inst_ready = 1'b1;
    tick();
  endtask

  task automatic test_flush();
    bus.inst_ready = 1'b1;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 13'h0031;
    tick();
    bus.fetch_req   = 1'b0;
    bus.fetch_flush = 1'b1;
    #1;
    total++;
    if (bus.fetch_ready !== 1'b0) begin
      bad++; $display("FAIL flush_ready got=%b want=0", bus.fetch_ready);
    end
    tick();
    bus.fetch_flush = 1'b0;
    total++;
    if (bus.inst_valid !== 1'b0) begin
      bad++; $display("FAIL flush_valid1 got=%b want=0", bus.inst_valid);
    end
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 13'h0010;
    tick();
    bus.fetch_req = 1'b0;
    total++;
    if (bus.inst_valid !== 1'b0) begin
      bad++; $display("FAIL flush_valid2 got=%b want=0", bus.inst_valid);
    end
    tick();
    total++;
    if (bus.inst_valid !== 1'b1 || bus.inst !== 16'hA55A) begin
      bad++; $display("FAIL flush_refetch got=%b/%h want=1/a55a", bus.inst_valid, bus.inst);
    end
    $display("flush: refetch valid=%b inst=%h", bus.inst_valid, bus.inst);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp [0:3];
    exp[0] = 16'hC001; exp[1] = 16'hC002; exp[2] = 16'hC003; exp[3] = 16'hC004;
    bus.inst_ready = 1'b1;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 13'h0040;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) bus.fetch_addr = 13'h0041 + 13'(i);
      else       bus.fetch_req  = 1'b0;
      tick();
      total++;
      if (bus.inst_valid !== 1'b1 || bus.inst !== exp[i]) begin
        bad++; $display("FAIL b2b_%0d got=%b/%h want=1/%h", i, bus.inst_valid, bus.inst, exp[i]);
      end
      $display("b2b: word=%0d valid=%b inst=%h", i, bus.inst_valid, bus.inst);
      tick();
      total++;
      if (bus.inst_valid !== 1'b0) begin
        bad++; $display("FAIL b2b_gap_%0d got=%b want=0", i, bus.inst_valid);
      end
    end
  endtask

  task automatic test_reset_midstream();
    bus.inst_ready = 1'b1;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 13'h0040;
    tick();
    bus.fetch_addr = 13'h0041;
    tick();
    #2;
    rst_async_n = 1'b0;
    bus.fetch_req = 1'b0;
    #1;
    total++;
    if (bus.inst_valid !== 1'b0 || bus.inst !== 16'h0000) begin
      bad++; $display("FAIL rst_mid got=%b/%h want=0/0000", bus.inst_valid, bus.inst);
    end
    $display("reset mid-stream: valid=%b inst=%h", bus.inst_valid, bus.inst);
    tick();
    rst_async_n = 1'b1;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 13'h0042;
    #1;
    total++;
    if (bus.fetch_ready !== 1'b1) begin
      bad++; $display("FAIL rst_first_ready got=%b want=1", bus.fetch_ready);
    end
    tick();
    bus.fetch_req = 1'b0;
    total++;
    if (bus.inst_valid !== 1'b0) begin
      bad++; $display("FAIL rst_no_pulse got=%b want=0", bus.inst_valid);
    end
    tick();
    total++;
    if (bus.inst_valid !== 1'b1 || bus.inst !== 16'hC003) begin
      bad++; $display("FAIL rst_first_fetch got=%b/%h want=1/c003", bus.inst_valid, bus.inst);
    end
    $display("reset recovery: valid=%b inst=%h", bus.inst_valid, bus.inst);
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_async_n = 1'b0;
    idle_inputs();
    test_reset();
    preload();
    test_basic();
    test_hold();
    test_write_priority();
    test_bypass();
    test_coherency();
    test_flush();
    test_back_to_back();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, the instruction word address width.
REQ-002 SHALL have parameter DATA_W, default 16, the instruction word width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port clk  input  1  rising-edge clock for all state.
REQ-005 Port rst_async_n  input  1  asynchronous active-low reset.
REQ-006 Port fetch_req  input  1  fetch unit requests one instruction word.
REQ-007 Port fetch_addr  input  ADDR_W  word address of the requested instruction.
REQ-008 Port fetch_ready  output  1  responder accepts the request this cycle.
REQ-009 Port fetch_flush  input  1  PC changed; discard any in-flight or held fetch.
REQ-010 Port inst_valid  output  1  inst holds a valid instruction word.
REQ-011 Port inst  output  DATA_W  returned instruction word.
REQ-012 Port inst_ready  input  1  fetch unit consumes inst this cycle.
REQ-013 Port wr_en  input  1  loader writes one word.
REQ-014 Port wr_addr  input  ADDR_W  loader write address.
REQ-015 Port wr_data  input  DATA_W  loader write data.
REQ-016 Port ram_addr  output  ADDR_W  single-port synchronous RAM address.
REQ-017 Port ram_we  output  1  RAM write enable.
REQ-018 Port ram_wdata  output  DATA_W  RAM write data.
REQ-019 Port ram_rdata  input  DATA_W  RAM read data, valid one cycle after the address.

Function
REQ-020 SHALL implement FSM states IDLE, READ and RESP.
REQ-021 A request SHALL be accepted when fetch_req and fetch_ready are high at a clock edge.
REQ-022 fetch_ready SHALL be 1 when (state is IDLE, or state is RESP and inst_ready is high) and wr_en is 0 and fetch_flush is 0; otherwise 0.
REQ-023 Writes SHALL have priority: wr_en high drives ram_we=1, ram_addr=wr_addr and ram_wdata=wr_data combinationally.
REQ-024 With wr_en low, ram_addr SHALL equal fetch_addr and ram_we SHALL be 0.
REQ-025 Acceptance SHALL move the FSM to READ; in READ the block SHALL capture ram_rdata into the inst register and move to RESP.
REQ-026 Bypass: if wr_en is high in READ with wr_addr equal to the pending address, inst SHALL capture wr_data instead of ram_rdata.
REQ-027 In RESP, inst_valid SHALL be 1; the FSM SHALL stay in RESP until inst_ready is high.
REQ-028 In RESP, inst_ready without a new acceptance SHALL move to IDLE; with a same-cycle acceptance SHALL move to READ (back-to-back).
REQ-029 Coherency: wr_en in RESP with wr_addr equal to the held address SHALL overwrite inst with wr_data; inst_valid stays 1.
REQ-030 Latency SHALL be two cycles: accepted at edge N, inst_valid=1 after edge N+2.
REQ-031 fetch_flush SHALL force the FSM to IDLE at the next edge from any state, and inst_valid SHALL be 0 after that edge.
REQ-032 inst SHALL hold its value when not being updated; inst_valid SHALL be 0 in IDLE and READ.
REQ-033 The pending/held address register SHALL be ADDR_W bits with no wrap or arithmetic.

Reset
REQ-034 While rst_async_n is 0, the FSM SHALL be IDLE, inst_valid=0, inst=0, the address register=0 and ram_we=0, regardless of clk.
REQ-035 Reset asserted mid-READ or mid-RESP SHALL discard the fetch; no inst_valid pulse SHALL follow deassertion.
REQ-036 After deassertion, the first edge SHALL be able to accept a request.

Verification
REQ-037 Preload RAM[0x0010]=0xA55A; request addr 0x0010 at edge 0 with inst_ready=1 -> inst_valid=1, inst=0xA55A after edge 2, for one cycle.
REQ-038 Hold inst_ready=0 for 5 cycles in RESP -> inst_valid and inst stay stable; fetch_ready=0 throughout.
REQ-039 Request addr 0x0020 with wr_en=1 on the same cycle -> fetch_ready=0, ram_we=1, not accepted; accepted on the next cycle with wr_en=0.
REQ-040 While in READ for addr 0x0030, write 0x1234 to 0x0030 -> inst=0x1234; a write to 0x0031 instead -> inst equals the RAM contents.
REQ-041 Assert fetch_flush in READ -> no inst_valid; a request on the next cycle returns correct data.
REQ-042 Stream 4 requests with inst_ready=1 continuously -> one word every 2 cycles in order, no drops; assert rst_async_n=0 mid-stream -> inst_valid=0 immediately.
